// File: rtl/mul_pkg.sv
// Shared definitions for the memory-mapped shift-add multiplier: FSM encodings,
// control-block offsets and STATUS field layout.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DONE = 2'b01,
    BUSY = 2'b10
  } state_e;

  localparam int INT_EN_OFS = 0;
  localparam int STATUS_OFS = 1;
  localparam int START_OFS  = 2;
  localparam int CLEAR_OFS  = 3;
  localparam int IRQ_OFS    = 4;

  localparam int STATUS_STATE_LSB = 0;
  localparam int STATUS_IRQ_BIT   = 2;
  localparam int STATUS_ERR_BIT   = 3;

  function automatic logic [31:0] pack_status(state_e st, logic irq_pend, logic err);
    logic [31:0] s;
    s = '0;
    s[STATUS_STATE_LSB +: 2] = st;
    s[STATUS_IRQ_BIT]        = irq_pend;
    s[STATUS_ERR_BIT]        = err;
    return s;
  endfunction

endpackage

// File: rtl/mul_shift_add_core.sv
// Iterative unsigned shift-add multiplier retiring STEP_BITS multiplier bits per
// cycle; done pulses for one cycle once the last partial product is accumulated.
module mul_shift_add_core #(
  parameter int WIDTH     = 64,
  parameter int STEP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int ITERS = WIDTH / STEP_BITS;
  localparam int CNT_W = $clog2(ITERS + 1);

  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   partial;

  // a_sh_q already carries the positional shift, so only the in-step bit offset is applied
  always_comb begin
    partial = '0;
    for (int i = 0; i < STEP_BITS; i++) begin
      if (b_q[i]) partial = partial + (a_sh_q << i);
    end
  end

  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    a_sh_d = a_sh_q;
    b_d    = b_q;
    if (abort) begin
      busy_d = 1'b0;
      cnt_d  = '0;
      acc_d  = '0;
    end else if (load) begin
      busy_d = 1'b1;
      cnt_d  = CNT_W'(ITERS);
      acc_d  = '0;
      a_sh_d = {{WIDTH{1'b0}}, a};
      b_d    = b;
    end else if (busy_q) begin
      acc_d  = acc_q + partial;
      a_sh_d = a_sh_q << STEP_BITS;
      b_d    = b_q >> STEP_BITS;
      cnt_d  = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      a_sh_q <= '0;
      b_q    <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      a_sh_q <= a_sh_d;
      b_q    <= b_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = acc_q;

endmodule

// File: rtl/mul_slave_engine.sv
// Bus-slave multiplier: register file, address decode, control FSM and level
// interrupt around the shift-add core.
//   state | meaning
//   IDLE  | operands writable, waiting for START
//   BUSY  | core iterating; operand writes and START flag err
//   DONE  | R holds the product, irq_pend set; CLEAR returns to IDLE
module mul_slave_engine import mul_pkg::*; #(
  parameter int WIDTH     = 64,
  parameter int STEP_BITS = 1,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              S_sel,
  input  logic              S_wr,
  input  logic [ADDR_W-1:0] S_address,
  input  logic [31:0]       S_din,
  output logic [31:0]       S_dout,
  output logic              m_interrupt
);

  localparam int N = WIDTH / 32;
  localparam int C = 4 * N;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0]   r_q, r_d;
  logic                 int_en_q, int_en_d;
  logic                 irq_pend_q, irq_pend_d;
  logic                 err_q, err_d;
  logic [31:0]          dout_q, dout_d;

  logic [31:0]          addr32;
  logic                 wr_en, rd_en;
  logic                 start_req, clear_req;
  logic                 core_load, core_abort, core_busy, core_done;
  logic                 store_result, locked;
  logic [2*WIDTH-1:0]   core_product;

  assign addr32    = 32'(S_address);
  assign wr_en     = S_sel & S_wr;
  assign rd_en     = S_sel & ~S_wr;
  assign start_req = wr_en && (addr32 == 32'(C + START_OFS)) && S_din[0];
  assign clear_req = wr_en && (addr32 == 32'(C + CLEAR_OFS)) && S_din[0];

  mul_shift_add_core #(
    .WIDTH     (WIDTH),
    .STEP_BITS (STEP_BITS)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .load    (core_load),
    .abort   (core_abort),
    .a       (a_q),
    .b       (b_q),
    .busy    (core_busy),
    .done    (core_done),
    .product (core_product)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear_req) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_req) state_d = BUSY;
        BUSY:    if (core_done) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // CLEAR outranks both a new START and the completing step
  always_comb begin
    core_load    = (state_q == IDLE) && start_req && !clear_req;
    core_abort   = clear_req;
    store_result = (state_q == BUSY) && core_done && !clear_req;
    locked       = (state_q == BUSY) || core_busy;
  end

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    r_d        = r_q;
    int_en_d   = int_en_q;
    irq_pend_d = irq_pend_q;
    err_d      = err_q;
    dout_d     = dout_q;

    if (wr_en) begin
      for (int k = 0; k < N; k++) begin
        if (addr32 == 32'(k)) begin
          if (locked) err_d = 1'b1;
          else        a_d[32*k +: 32] = S_din;
        end
        if (addr32 == 32'(N + k)) begin
          if (locked) err_d = 1'b1;
          else        b_d[32*k +: 32] = S_din;
        end
      end
      if (addr32 == 32'(C + INT_EN_OFS) && !locked) int_en_d = S_din[0];
      if (start_req && state_q != IDLE) err_d = 1'b1;
      if (addr32 == 32'(C + IRQ_OFS)) begin
        if (S_din[0]) irq_pend_d = 1'b0;
        if (S_din[1]) err_d      = 1'b0;
      end
    end

    // applied after the W1C so a same-cycle completion keeps irq_pend set
    if (clear_req) begin
      r_d        = '0;
      irq_pend_d = 1'b0;
    end else if (store_result) begin
      r_d        = core_product;
      irq_pend_d = 1'b1;
    end

    if (rd_en) begin
      dout_d = '0;
      for (int k = 0; k < N; k++) begin
        if (addr32 == 32'(k))     dout_d = a_q[32*k +: 32];
        if (addr32 == 32'(N + k)) dout_d = b_q[32*k +: 32];
      end
      for (int j = 0; j < 2*N; j++) begin
        if (addr32 == 32'(2*N + j)) dout_d = r_q[32*j +: 32];
      end
      if (addr32 == 32'(C + INT_EN_OFS)) dout_d = {31'b0, int_en_q};
      if (addr32 == 32'(C + STATUS_OFS)) dout_d = pack_status(state_q, irq_pend_q, err_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q        <= '0;
      b_q        <= '0;
      r_q        <= '0;
      int_en_q   <= 1'b0;
      irq_pend_q <= 1'b0;
      err_q      <= 1'b0;
      dout_q     <= '0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      r_q        <= r_d;
      int_en_q   <= int_en_d;
      irq_pend_q <= irq_pend_d;
      err_q      <= err_d;
      dout_q     <= dout_d;
    end
  end

  assign S_dout      = dout_q;
  assign m_interrupt = irq_pend_q & int_en_q;

endmodule

// File: tb/tb_mul_slave_engine.sv
// Directed bench: a 64-bit/1-bit-step engine and a 128-bit/2-bit-step engine on
// separate buses, shared clock and reset.
module tb_mul_slave_engine;

  logic        clk;
  logic        reset;
  logic        sel0, wr0, sel1, wr1;
  logic [7:0]  addr0, addr1;
  logic [31:0] din0, din1, dout0, dout1;
  logic        irq0, irq1;
  logic [31:0] rd;

  int pass_cnt  = 0;
  int total_cnt = 0;

  mul_slave_engine #(.WIDTH(64), .STEP_BITS(1), .ADDR_W(8)) dut64 (
    .clk(clk), .reset(reset), .S_sel(sel0), .S_wr(wr0), .S_address(addr0),
    .S_din(din0), .S_dout(dout0), .m_interrupt(irq0)
  );

  mul_slave_engine #(.WIDTH(128), .STEP_BITS(2), .ADDR_W(8)) dut128 (
    .clk(clk), .reset(reset), .S_sel(sel1), .S_wr(wr1), .S_address(addr1),
    .S_din(din1), .S_dout(dout1), .m_interrupt(irq1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // called at a negedge; the access is captured on the following posedge
  task automatic drive(input int d, input logic w, input logic [7:0] a, input logic [31:0] v);
    if (d == 0) begin sel0 = 1'b1; wr0 = w; addr0 = a; din0 = v; end
    else        begin sel1 = 1'b1; wr1 = w; addr1 = a; din1 = v; end
    @(negedge clk);
    sel0 = 1'b0; wr0 = 1'b0; sel1 = 1'b0; wr1 = 1'b0;
  endtask

  task automatic bus_wr(input int d, input logic [7:0] a, input logic [31:0] v);
    drive(d, 1'b1, a, v);
  endtask

  task automatic bus_rd(input int d, input logic [7:0] a, output logic [31:0] v);
    drive(d, 1'b0, a, 32'h0);
    v = (d == 0) ? dout0 : dout1;
  endtask

  initial begin
    logic [31:0] exp_r64 [4];
    logic [31:0] exp_r128 [8];
    reset = 1'b1;
    sel0 = 1'b0; wr0 = 1'b0; addr0 = '0; din0 = '0;
    sel1 = 1'b0; wr1 = 1'b0; addr1 = '0; din1 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1: reset in the middle of an operation
    bus_wr(0, 8'h08, 32'h1);
    bus_wr(0, 8'h00, 32'h5);
    bus_wr(0, 8'h02, 32'h3);
    bus_rd(0, 8'h08, rd);
    check("int_en_before_reset", rd, 32'h1);
    bus_wr(0, 8'h0A, 32'h1);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("dout_after_reset", dout0, 32'h0);
    check("irq_after_reset", {31'b0, irq0}, 32'h0);
    bus_rd(0, 8'h09, rd); check("status_after_reset", rd, 32'h0);
    bus_rd(0, 8'h08, rd); check("int_en_after_reset", rd, 32'h0);
    bus_rd(0, 8'h00, rd); check("a0_after_reset", rd, 32'h0);
    bus_rd(0, 8'h02, rd); check("b0_after_reset", rd, 32'h0);
    repeat (70) @(negedge clk);
    bus_rd(0, 8'h09, rd); check("status_no_late_done", rd, 32'h0);
    bus_rd(0, 8'h04, rd); check("r0_after_reset", rd, 32'h0);

    // 2: max x max with latency check
    bus_wr(0, 8'h00, 32'hFFFF_FFFF);
    bus_wr(0, 8'h01, 32'hFFFF_FFFF);
    bus_wr(0, 8'h02, 32'hFFFF_FFFF);
    bus_wr(0, 8'h03, 32'hFFFF_FFFF);
    bus_wr(0, 8'h0A, 32'h1);
    repeat (64) @(negedge clk);
    bus_rd(0, 8'h09, rd); check("max_status_t64", rd, 32'h2);
    bus_rd(0, 8'h09, rd); check("max_status_t65", rd, 32'h5);
    check("max_irq_masked", {31'b0, irq0}, 32'h0);
    exp_r64[0] = 32'h0000_0001; exp_r64[1] = 32'h0000_0000;
    exp_r64[2] = 32'hFFFF_FFFE; exp_r64[3] = 32'hFFFF_FFFF;
    for (int j = 0; j < 4; j++) begin
      bus_rd(0, 8'(4 + j), rd);
      check($sformatf("max_r%0d", j), rd, exp_r64[j]);
    end

    // 3: small product, interrupt and W1C
    bus_wr(0, 8'h0B, 32'h1);
    bus_rd(0, 8'h09, rd); check("clear_status", rd, 32'h0);
    bus_rd(0, 8'h05, rd); check("clear_r1", rd, 32'h0);
    bus_wr(0, 8'h08, 32'h1);
    bus_wr(0, 8'h00, 32'h3);
    bus_wr(0, 8'h01, 32'h0);
    bus_wr(0, 8'h02, 32'h5);
    bus_wr(0, 8'h03, 32'h0);
    bus_wr(0, 8'h0A, 32'h1);
    repeat (70) @(negedge clk);
    check("small_irq_high", {31'b0, irq0}, 32'h1);
    bus_rd(0, 8'h04, rd); check("small_r0", rd, 32'd15);
    bus_rd(0, 8'h05, rd); check("small_r1", rd, 32'h0);
    bus_wr(0, 8'h0C, 32'h1);
    check("small_irq_cleared", {31'b0, irq0}, 32'h0);
    bus_rd(0, 8'h09, rd); check("small_status_done", rd, 32'h1);

    // 4: writes while busy are rejected and flagged
    bus_wr(0, 8'h0B, 32'h1);
    bus_wr(0, 8'h0A, 32'h1);
    bus_wr(0, 8'h00, 32'h7);
    bus_wr(0, 8'h0A, 32'h1);
    repeat (70) @(negedge clk);
    bus_rd(0, 8'h04, rd); check("busy_wr_r0", rd, 32'd15);
    bus_rd(0, 8'h09, rd); check("busy_wr_status_err", rd, 32'hD);
    bus_wr(0, 8'h0C, 32'h2);
    bus_rd(0, 8'h09, rd); check("err_cleared", rd, 32'h5);
    bus_rd(0, 8'h00, rd); check("a0_kept", rd, 32'h3);
    repeat (3) @(negedge clk);
    check("dout_hold", dout0, 32'h3);
    bus_rd(0, 8'hFF, rd); check("unmapped_read", rd, 32'h0);
    bus_rd(0, 8'h0A, rd); check("start_read_zero", rd, 32'h0);

    // 5: CLEAR on the completing cycle wins
    bus_wr(0, 8'h0B, 32'h1);
    bus_wr(0, 8'h0A, 32'h1);
    repeat (64) @(negedge clk);
    bus_wr(0, 8'h0B, 32'h1);
    check("abort_irq", {31'b0, irq0}, 32'h0);
    bus_rd(0, 8'h09, rd); check("abort_status", rd, 32'h0);
    for (int j = 0; j < 4; j++) begin
      bus_rd(0, 8'(4 + j), rd);
      check($sformatf("abort_r%0d", j), rd, 32'h0);
    end
    repeat (5) @(negedge clk);
    bus_rd(0, 8'h09, rd); check("abort_status_later", rd, 32'h0);

    // 6: 128-bit engine, two bits per step
    bus_wr(1, 8'h03, 32'h8000_0000);
    bus_wr(1, 8'h04, 32'h2);
    bus_wr(1, 8'h12, 32'h1);
    repeat (64) @(negedge clk);
    bus_rd(1, 8'h11, rd); check("w128_status_t64", rd, 32'h2);
    bus_rd(1, 8'h11, rd); check("w128_status_t65", rd, 32'h5);
    check("w128_irq_masked", {31'b0, irq1}, 32'h0);
    for (int j = 0; j < 8; j++) exp_r128[j] = (j == 4) ? 32'h1 : 32'h0;
    for (int j = 0; j < 8; j++) begin
      bus_rd(1, 8'(8 + j), rd);
      check($sformatf("w128_r%0d", j), rd, exp_r128[j]);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
